biquad_inverse_seq: RTL and testbench

Sequential inverse of the team's second-order direct-form-II IIR section. It recovers the filter input sample x from the unscaled section output (the pre-shift w2 stream). It is used as an equaliser and loop-back checker after the forward biquad. One time-shared 2·bitwidth multiply-accumulate datapath computes each sample over 7 cycles. Valid/ready streaming is used on both sides, and coefficients are runtime-writable.

---
 rtl/biquad_pkg.sv | 38 +++
 rtl/biquad_mac.sv | 56 +++++
 rtl/biquad_inverse_seq.sv | 191 +++++++++++++++++++
 tb/tb_biquad_inverse_seq.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/biquad_pkg.sv
// Shared definitions for the forward and inverse direct-form-II biquad sections:
// coefficient map, sequencer states, MAC opcodes and the identity coefficient.
package biquad_pkg;

  localparam int BW_DEFAULT   = 32;
  localparam int FRAC_DEFAULT = 20;

  localparam logic [2:0] CO_B0    = 3'd0;
  localparam logic [2:0] CO_B1    = 3'd1;
  localparam logic [2:0] CO_B2    = 3'd2;
  localparam logic [2:0] CO_A1    = 3'd3;
  localparam logic [2:0] CO_A2    = 3'd4;
  localparam logic [2:0] CO_INVB0 = 3'd5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S_B1 = 3'd1,
    S_B2 = 3'd2,
    S_SC = 3'd3,
    S_A1 = 3'd4,
    S_A2 = 3'd5,
    OUT  = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    MAC_NOP        = 3'd0,
    MAC_LOAD_SHIFT = 3'd1,
    MAC_SUB        = 3'd2,
    MAC_ADD        = 3'd3,
    MAC_MUL_SCALE  = 3'd4
  } mac_op_t;

  // 1.0 in Q.frac, wide enough to be cut down to any sample width
  function automatic logic signed [63:0] identity_coef(input int frac);
    identity_coef = 64'sd1 <<< frac;
  endfunction

endpackage

// File: rtl/biquad_mac.sv
// Registered 2*BW signed multiply-accumulate with a single shared multiplier.
// acc_nxt is the value the accumulator takes on the coming edge.
module biquad_mac
  import biquad_pkg::*;
#(
  parameter int BW   = BW_DEFAULT,
  parameter int FRAC = FRAC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  mac_op_t                op,
  input  logic                   neg,
  input  logic signed [2*BW-1:0] base,
  input  logic signed [2*BW-1:0] opnd,
  input  logic signed [BW-1:0]   coef,
  output logic signed [2*BW-1:0] acc_nxt
);

  logic signed [2*BW-1:0] acc_r;
  logic signed [2*BW-1:0] mul_a_s;
  logic signed [2*BW-1:0] mul_b_s;
  logic signed [2*BW-1:0] prod_s;

  // MUL_SCALE rescales the accumulator itself, otherwise the state operand is multiplied
  assign mul_a_s = (op == MAC_MUL_SCALE) ? (acc_r >>> FRAC) : opnd;
  assign mul_b_s = {{BW{coef[BW-1]}}, coef};
  assign prod_s  = mul_a_s * mul_b_s;

  // Next accumulator value per opcode
  always_comb begin
    acc_nxt = acc_r;
    case (op)
      MAC_LOAD_SHIFT: begin
        if (neg) begin
          acc_nxt = (base <<< FRAC) - prod_s;
        end else begin
          acc_nxt = (base <<< FRAC) + prod_s;
        end
      end
      MAC_SUB:       acc_nxt = acc_r - prod_s;
      MAC_ADD:       acc_nxt = acc_r + prod_s;
      MAC_MUL_SCALE: acc_nxt = prod_s >>> FRAC;
      default:       acc_nxt = acc_r;
    endcase
  end

  // Accumulator register
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= {2*BW{1'b0}};
    end else begin
      acc_r <= acc_nxt;
    end
  end

endmodule

// File: rtl/biquad_inverse_seq.sv
// Sequential inverse of the DF-II biquad: recovers x from the unscaled section
// output over seven cycles per sample on one time-shared MAC.
module biquad_inverse_seq
  import biquad_pkg::*;
#(
  parameter int bitwidth = BW_DEFAULT,
  parameter int FRAC     = FRAC_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [bitwidth-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [bitwidth-1:0] out_data,
  input  logic                       cfg_we,
  input  logic [2:0]                 cfg_addr,
  input  logic signed [bitwidth-1:0] cfg_data,
  output logic                       cfg_busy
);

  localparam int W2 = 2 * bitwidth;
  localparam logic signed [bitwidth-1:0] COEF_ONE = bitwidth'(identity_coef(FRAC));

  state_t state_r;
  state_t state_nxt_s;

  // b0 is held only so a debugger can see what software programmed
  logic signed [bitwidth-1:0] b0_dbg_unused_r;
  logic signed [bitwidth-1:0] b1_r, b2_r, a1_r, a2_r, inv_b0_r;
  logic signed [bitwidth-1:0] y_r;
  logic signed [bitwidth-1:0] out_data_r;
  logic signed [W2-1:0]       w1_r, z1_r, z2_r;

  logic                       in_ready_s;
  logic                       out_valid_s;
  logic                       in_fire_s;
  logic                       out_fire_s;
  mac_op_t                    mac_op_s;
  logic                       mac_neg_s;
  logic signed [W2-1:0]       mac_base_s;
  logic signed [W2-1:0]       mac_opnd_s;
  logic signed [bitwidth-1:0] mac_coef_s;
  logic signed [W2-1:0]       mac_acc_nxt_s;

  assign in_fire_s  = in_valid & in_ready_s;
  assign out_fire_s = out_valid_s & out_ready;

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Sequencer next state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt_s = S_B1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      S_B1: state_nxt_s = S_B2;
      S_B2: state_nxt_s = S_SC;
      S_SC: state_nxt_s = S_A1;
      S_A1: state_nxt_s = S_A2;
      S_A2: state_nxt_s = OUT;
      OUT: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = OUT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Per-state handshakes and MAC operand selection
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    mac_op_s    = MAC_NOP;
    mac_neg_s   = 1'b0;
    mac_base_s  = {W2{1'b0}};
    mac_opnd_s  = {W2{1'b0}};
    mac_coef_s  = {bitwidth{1'b0}};
    case (state_r)
      IDLE: in_ready_s = 1'b1;
      S_B1: begin
        mac_op_s   = MAC_LOAD_SHIFT;
        mac_neg_s  = 1'b1;
        mac_base_s = {{bitwidth{y_r[bitwidth-1]}}, y_r};
        mac_opnd_s = z1_r;
        mac_coef_s = b1_r;
      end
      S_B2: begin
        mac_op_s   = MAC_SUB;
        mac_opnd_s = z2_r;
        mac_coef_s = b2_r;
      end
      S_SC: begin
        mac_op_s   = MAC_MUL_SCALE;
        mac_coef_s = inv_b0_r;
      end
      S_A1: begin
        mac_op_s   = MAC_LOAD_SHIFT;
        mac_base_s = w1_r;
        mac_opnd_s = z1_r;
        mac_coef_s = a1_r;
      end
      S_A2: begin
        mac_op_s   = MAC_ADD;
        mac_opnd_s = z2_r;
        mac_coef_s = a2_r;
      end
      OUT:     out_valid_s = 1'b1;
      default: mac_op_s = MAC_NOP;
    endcase
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign cfg_busy  = ~in_ready_s;
  assign out_data  = out_data_r;

  biquad_mac #(
    .BW   (bitwidth),
    .FRAC (FRAC)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .op      (mac_op_s),
    .neg     (mac_neg_s),
    .base    (mac_base_s),
    .opnd    (mac_opnd_s),
    .coef    (mac_coef_s),
    .acc_nxt (mac_acc_nxt_s)
  );

  // Coefficients, sample latch, w1 hold, delay line and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      b0_dbg_unused_r <= COEF_ONE;
      inv_b0_r        <= COEF_ONE;
      b1_r            <= {bitwidth{1'b0}};
      b2_r            <= {bitwidth{1'b0}};
      a1_r            <= {bitwidth{1'b0}};
      a2_r            <= {bitwidth{1'b0}};
      y_r             <= {bitwidth{1'b0}};
      out_data_r      <= {bitwidth{1'b0}};
      w1_r            <= {W2{1'b0}};
      z1_r            <= {W2{1'b0}};
      z2_r            <= {W2{1'b0}};
    end else begin
      if (cfg_we && in_ready_s) begin
        case (cfg_addr)
          CO_B0:    b0_dbg_unused_r <= cfg_data;
          CO_B1:    b1_r            <= cfg_data;
          CO_B2:    b2_r            <= cfg_data;
          CO_A1:    a1_r            <= cfg_data;
          CO_A2:    a2_r            <= cfg_data;
          CO_INVB0: inv_b0_r        <= cfg_data;
          default:  ;
        endcase
      end
      if (in_fire_s) begin
        y_r <= in_data;
      end
      if (state_r == S_SC) begin
        w1_r <= mac_acc_nxt_s;
      end
      if (state_r == S_A2) begin
        out_data_r <= bitwidth'(mac_acc_nxt_s >>> FRAC);
      end
      // the delay line only advances once the recovered sample is taken
      if (out_fire_s) begin
        z2_r <= z1_r;
        z1_r <= w1_r;
      end
    end
  end

endmodule

// File: tb/tb_biquad_inverse_seq.sv
// Self-checking bench for biquad_inverse_seq: directed vector table, hand-written
// backpressure / reset / same-cycle-config sequences, and randomized samples.
module tb_biquad_inverse_seq;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_data;
  logic               cfg_we;
  logic [2:0]         cfg_addr;
  logic signed [31:0] cfg_data;
  logic               cfg_busy;

  int n_pass  = 0;
  int n_total = 0;

  // reference model state: coefficients by address and the w delay line
  longint co [6];
  longint mz1, mz2;

  typedef struct {
    bit       is_cfg;
    bit [2:0] addr;
    int       val;
    int       exp;
  } vec_t;

  vec_t vecs[$];

  biquad_inverse_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_busy  (cfg_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) co[i] = 0;
    co[0] = 64'sd1 <<< 20;
    co[5] = 64'sd1 <<< 20;
    mz1 = 0;
    mz2 = 0;
  endtask

  // inverse section in plain arithmetic: t, w1, x, then shift the delay line
  function automatic int model_step(input int y);
    longint t, w, x;
    t = ((longint'(y) <<< 20) - co[1] * mz1 - co[2] * mz2) >>> 20;
    w = (t * co[5]) >>> 20;
    x = ((w <<< 20) + co[3] * mz1 + co[4] * mz2) >>> 20;
    mz2 = mz1;
    mz1 = w;
    return int'(x);
  endfunction

  function automatic vec_t mk(input bit c, input bit [2:0] a, input int v, input int e);
    vec_t r;
    r.is_cfg = c;
    r.addr   = a;
    r.val    = v;
    r.exp    = e;
    return r;
  endfunction

  // all tasks start and end just after a falling edge
  task automatic cfg_write(input bit [2:0] a, input int v, input bit track);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = v;
    @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b0;
    if (track && a < 3'd6) co[a] = v;
  endtask

  task automatic start_wait(input int y, input bit with_cfg, input bit [2:0] a, input int v,
                            output int got, output int lat, output bit busy_ok);
    int guard;
    in_data  = y;
    in_valid = 1'b1;
    if (with_cfg) begin
      cfg_we   = 1'b1;
      cfg_addr = a;
      cfg_data = v;
    end
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    lat      = 0;
    busy_ok  = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (in_ready) busy_ok = 1'b0;
    if (!out_valid) lat = -1;
    got = out_data;
  endtask

  task automatic finish_out(output bit ready_after);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready_after = in_ready;
  endtask

  task automatic do_sample(input string name, input int y, input int exp);
    int got, lat;
    bit busy_ok, rdy;
    start_wait(y, 1'b0, 3'd0, 0, got, lat, busy_ok);
    check({name, "_data"}, got, exp);
    check({name, "_latency"}, lat, 5);
    check({name, "_busy"}, busy_ok, 1);
    finish_out(rdy);
    check({name, "_ready_after"}, rdy, 1);
  endtask

  initial begin
    int got, lat, e, y, v;
    bit busy_ok, rdy;
    bit [2:0] a;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 0;
    out_ready = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = 3'd0;
    cfg_data  = 0;
    model_reset();

    vecs.push_back(mk(1'b0, 3'd0, 1234, 1234));
    vecs.push_back(mk(1'b0, 3'd0, -5, -5));
    vecs.push_back(mk(1'b1, 3'd0, 524288, 0));
    vecs.push_back(mk(1'b1, 3'd5, 2097152, 0));
    vecs.push_back(mk(1'b0, 3'd0, 100, 200));
    vecs.push_back(mk(1'b1, 3'd5, 1048576, 0));
    vecs.push_back(mk(1'b1, 3'd0, 1048576, 0));
    vecs.push_back(mk(1'b0, 3'd0, 0, 0));
    vecs.push_back(mk(1'b0, 3'd0, 0, 0));
    vecs.push_back(mk(1'b1, 3'd3, 524288, 0));
    vecs.push_back(mk(1'b0, 3'd0, 1000, 1000));
    vecs.push_back(mk(1'b0, 3'd0, 0, 500));
    vecs.push_back(mk(1'b0, 3'd0, 0, 0));
    vecs.push_back(mk(1'b1, 3'd4, 262144, 0));
    vecs.push_back(mk(1'b0, 3'd0, 1000, 1000));
    vecs.push_back(mk(1'b0, 3'd0, 0, 500));
    vecs.push_back(mk(1'b0, 3'd0, 0, 250));
    vecs.push_back(mk(1'b1, 3'd3, 0, 0));
    vecs.push_back(mk(1'b1, 3'd4, 0, 0));
    vecs.push_back(mk(1'b1, 3'd1, 524288, 0));
    vecs.push_back(mk(1'b0, 3'd0, 1000, 1000));
    vecs.push_back(mk(1'b0, 3'd0, 0, -500));
    vecs.push_back(mk(1'b0, 3'd0, 0, 250));
    vecs.push_back(mk(1'b0, 3'd0, 0, -125));
    vecs.push_back(mk(1'b1, 3'd1, 0, 0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_cfg_busy", cfg_busy, 0);

    foreach (vecs[i]) begin
      if (vecs[i].is_cfg) begin
        cfg_write(vecs[i].addr, vecs[i].val, 1'b1);
      end else begin
        void'(model_step(vecs[i].val));
        do_sample($sformatf("vec%0d", i), vecs[i].val, vecs[i].exp);
      end
    end

    // backpressure: output frozen, busy, and a config write is dropped
    out_ready = 1'b0;
    start_wait(4000, 1'b0, 3'd0, 0, got, lat, busy_ok);
    check("bp_data", got, 4000);
    check("bp_latency", lat, 5);
    for (int k = 0; k < 10; k++) begin
      check("bp_hold_data", out_data, 4000);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_in_ready", in_ready, 0);
      check("bp_hold_cfg_busy", cfg_busy, 1);
      cfg_we   = (k == 2);
      cfg_addr = 3'd3;
      cfg_data = 524288;
      @(posedge clk);
      @(negedge clk);
    end
    cfg_we = 1'b0;
    finish_out(rdy);
    check("bp_ready_after", rdy, 1);
    void'(model_step(4000));
    void'(model_step(321));
    do_sample("bp_next", 321, 321);

    // reset while in S_A1 discards the sample and restores identity
    cfg_write(3'd3, 524288, 1'b1);
    e = model_step(600);
    do_sample("pre_rst", 600, e);
    in_data  = 999;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_cfg_busy", cfg_busy, 0);
    rst = 1'b0;
    model_reset();
    void'(model_step(77));
    do_sample("post_rst", 77, 77);

    // config write and input handshake in the same IDLE cycle
    co[3] = 524288;
    e = model_step(10);
    start_wait(10, 1'b1, 3'd3, 524288, got, lat, busy_ok);
    check("samecyc_data", got, e);
    check("samecyc_latency", lat, 5);
    finish_out(rdy);
    check("samecyc_ready_after", rdy, 1);

    // randomized coefficients (including reserved addresses) and samples
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        a = 3'($urandom_range(0, 7));
        if (a == 3'd5) v = int'($urandom_range(524288, 2097152));
        else v = int'($urandom_range(0, 1048576)) - 524288;
        cfg_write(a, v, 1'b1);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      y = int'($urandom_range(0, 65535)) - 32768;
      e = model_step(y);
      do_sample($sformatf("rand%0d", n), y, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
